// File: rtl/regfile_pkg.sv
// Shared defaults for the decode-stage register file and its PC shadow stack.
package regfile_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ADDR_W    = 3;
  localparam int DEF_NUM_RD    = 2;
  localparam int DEF_PC_W      = 32;
  localparam int DEF_STK_DEPTH = 4;
  localparam int DEF_IN_ADDR   = 6;
  localparam int DEF_OUT_ADDR  = 7;

  // Count must reach STK_DEPTH itself, so one bit more than the pointer.
  function automatic int stk_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pc_shadow_stack.sv
// PC shadow stack for nested interrupt/call save; sticky err on overflow/underflow.
module pc_shadow_stack
  import regfile_pkg::*;
#(
  parameter int PC_W      = DEF_PC_W,
  parameter int STK_DEPTH = DEF_STK_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] dout,
  output logic            full,
  output logic            empty,
  output logic            err
);

  localparam int CNT_W = stk_cnt_w(STK_DEPTH);
  localparam int PTR_W = $clog2(STK_DEPTH);

  logic [CNT_W-1:0] count_q, count_d;
  logic [PC_W-1:0]  mem_q [STK_DEPTH];
  logic [PC_W-1:0]  mem_d [STK_DEPTH];
  logic             err_q, err_d;
  logic [PTR_W-1:0] wr_ptr, top_ptr;

  assign wr_ptr  = count_q[PTR_W-1:0];
  assign top_ptr = wr_ptr - PTR_W'(1);
  assign full    = (count_q == CNT_W'(STK_DEPTH));
  assign empty   = (count_q == '0);
  assign dout    = empty ? '0 : mem_q[top_ptr];
  assign err     = err_q;

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    err_d   = err_q;
    if (push && pop && !empty) begin
      mem_d[top_ptr] = din;
    end else if (push) begin
      // push+pop on an empty stack lands here and behaves as a plain push
      if (full) begin
        err_d = 1'b1;
      end else begin
        mem_d[wr_ptr] = din;
        count_d       = count_q + CNT_W'(1);
      end
    end else if (pop) begin
      if (empty) err_d = 1'b1;
      else       count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < STK_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/param_reg_file.sv
// Decode-stage register file: NUM_RD registered read ports, one write port, IN/OUT port
// registers and a PC shadow stack. Define REGFILE_WR_BYPASS_EN for same-cycle write-to-read bypass.
module param_reg_file
  import regfile_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_RD    = DEF_NUM_RD,
  parameter int PC_W      = DEF_PC_W,
  parameter int STK_DEPTH = DEF_STK_DEPTH,
  parameter int IN_ADDR   = DEF_IN_ADDR,
  parameter int OUT_ADDR  = DEF_OUT_ADDR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W-1:0]        inport,
  output logic [DATA_W-1:0]        outport,
  input  logic                     pc_push,
  input  logic                     pc_pop,
  input  logic [PC_W-1:0]          pc_in,
  output logic [PC_W-1:0]          pc_out,
  output logic                     pc_full,
  output logic                     pc_empty,
  output logic                     pc_err
);

  localparam int                NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] IN_A  = ADDR_W'(IN_ADDR);
  localparam logic [ADDR_W-1:0] OUT_A = ADDR_W'(OUT_ADDR);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [DATA_W-1:0] in_reg_q, in_reg_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] rd_q [NUM_RD];
  logic [DATA_W-1:0] rd_d [NUM_RD];
  logic [ADDR_W-1:0] rd_a [NUM_RD];

  genvar k;
  generate
    for (k = 0; k < NUM_RD; k++) begin : g_rd
      assign rd_a[k]                      = rd_addr[k*ADDR_W +: ADDR_W];
      assign rd_data[k*DATA_W +: DATA_W]  = rd_q[k];
    end
  endgenerate

  always_comb begin
    regs_d   = regs_q;
    out_d    = out_q;
    in_reg_d = inport;
    if (wr_en) begin
      regs_d[wr_addr] = wr_data;
      if (wr_addr == OUT_A) out_d = wr_data;
    end
  end

  // IN_ADDR always reads the sampled input port, never the array entry behind it
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_d[p] = regs_q[rd_a[p]];
`ifdef REGFILE_WR_BYPASS_EN
      if (wr_en && (rd_a[p] == wr_addr)) rd_d[p] = wr_data;
`endif
      if (rd_a[p] == IN_A) rd_d[p] = in_reg_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_reg_q <= '0;
      out_q    <= '0;
      for (int i = 0; i < NREGS; i++)  regs_q[i] <= '0;
      for (int p = 0; p < NUM_RD; p++) rd_q[p]   <= '0;
    end else begin
      in_reg_q <= in_reg_d;
      out_q    <= out_d;
      regs_q   <= regs_d;
      rd_q     <= rd_d;
    end
  end

  assign outport = out_q;

  pc_shadow_stack #(
    .PC_W      (PC_W),
    .STK_DEPTH (STK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (pc_push),
    .pop   (pc_pop),
    .din   (pc_in),
    .dout  (pc_out),
    .full  (pc_full),
    .empty (pc_empty),
    .err   (pc_err)
  );

endmodule

// File: tb/tb_param_reg_file.sv
// Self-checking bench for param_reg_file: directed scenarios then random traffic vs a queue/array model.
module tb_param_reg_file;

  localparam int DATA_W = 16, ADDR_W = 3, NUM_RD = 2, PC_W = 32, STK_DEPTH = 4;
  localparam int IN_ADDR = 6, OUT_ADDR = 7;
`ifdef REGFILE_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [DATA_W-1:0]        inport;
  logic [DATA_W-1:0]        outport;
  logic                     pc_push, pc_pop;
  logic [PC_W-1:0]          pc_in, pc_out;
  logic                     pc_full, pc_empty, pc_err;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [DATA_W-1:0] m_regs [2**ADDR_W];
  logic [DATA_W-1:0] m_in, m_out;
  logic [DATA_W-1:0] m_rd [NUM_RD];
  logic [PC_W-1:0]   m_stk [$];
  bit                m_err;

  always #5 clk = ~clk;

  param_reg_file #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .PC_W(PC_W),
    .STK_DEPTH(STK_DEPTH), .IN_ADDR(IN_ADDR), .OUT_ADDR(OUT_ADDR)
  ) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .inport(inport), .outport(outport),
    .pc_push(pc_push), .pc_pop(pc_pop), .pc_in(pc_in), .pc_out(pc_out),
    .pc_full(pc_full), .pc_empty(pc_empty), .pc_err(pc_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] ra(input int p);
    logic [NUM_RD*ADDR_W-1:0] v;
    v = rd_addr;
    return v[p*ADDR_W +: ADDR_W];
  endfunction

  task automatic model_edge();
    logic [DATA_W-1:0] nrd [NUM_RD];
    int a;
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      foreach (m_rd[i]) m_rd[i] = '0;
      m_in = '0; m_out = '0; m_err = 0;
      m_stk.delete();
      return;
    end
    for (int p = 0; p < NUM_RD; p++) begin
      a = int'(ra(p));
      if (a == IN_ADDR)                                     nrd[p] = m_in;
      else if (BYP && wr_en && a == int'(wr_addr))          nrd[p] = wr_data;
      else                                                  nrd[p] = m_regs[a];
    end
    foreach (m_rd[i]) m_rd[i] = nrd[i];
    if (wr_en) begin
      m_regs[wr_addr] = wr_data;
      if (int'(wr_addr) == OUT_ADDR) m_out = wr_data;
    end
    m_in = inport;
    if (pc_push && pc_pop && m_stk.size() > 0)   m_stk[m_stk.size()-1] = pc_in;
    else if (pc_push) begin
      if (m_stk.size() == STK_DEPTH) m_err = 1;
      else                           m_stk.push_back(pc_in);
    end else if (pc_pop) begin
      if (m_stk.size() == 0) m_err = 1;
      else                   void'(m_stk.pop_back());
    end
  endtask

  task automatic check_all(input string tag);
    for (int p = 0; p < NUM_RD; p++)
      chk($sformatf("%s rd_data%0d", tag, p), 32'(rd_data[p*DATA_W +: DATA_W]), 32'(m_rd[p]));
    chk({tag, " outport"}, 32'(outport), 32'(m_out));
    chk({tag, " pc_out"}, pc_out, (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : 32'h0);
    chk({tag, " pc_full"}, 32'(pc_full), 32'(m_stk.size() == STK_DEPTH));
    chk({tag, " pc_empty"}, 32'(pc_empty), 32'(m_stk.size() == 0));
    chk({tag, " pc_err"}, 32'(pc_err), 32'(m_err));
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    rst = 0; wr_en = 0; pc_push = 0; pc_pop = 0;
  endtask

  task automatic push(input logic [PC_W-1:0] v, input string tag);
    pc_push = 1; pc_pop = 0; pc_in = v;
    cyc(tag);
    pc_push = 0;
  endtask

  task automatic pop(input string tag);
    pc_push = 0; pc_pop = 1;
    cyc(tag);
    pc_pop = 0;
  endtask

  initial begin
    foreach (m_regs[i]) m_regs[i] = '0;
    foreach (m_rd[i]) m_rd[i] = '0;
    m_in = '0; m_out = '0; m_err = 0;
    rst = 1; rd_addr = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
    inport = '0; pc_push = 0; pc_pop = 0; pc_in = '0;

    // 1: reset
    cyc("reset");
    chk("reset pc_empty const", 32'(pc_empty), 32'd1);
    idle();

    // 2: write r3, read back on port0, port1 on r0
    wr_en = 1; wr_addr = 3'd3; wr_data = 16'hBEEF;
    cyc("wr_r3");
    wr_en = 0; rd_addr = {3'd0, 3'd3};
    cyc("rd_r3");
    chk("rd_r3 const", 32'(rd_data[15:0]), 32'h0000_BEEF);
    chk("rd_r0 const", 32'(rd_data[31:16]), 32'h0);

    // 3: OUT/IN port registers
    wr_en = 1; wr_addr = 3'(OUT_ADDR); wr_data = 16'h1234;
    cyc("wr_out");
    chk("outport const", 32'(outport), 32'h1234);
    wr_en = 0; inport = 16'hA5A5; rd_addr = {3'd0, 3'(IN_ADDR)};
    cyc("in_sample");
    cyc("in_read");
    chk("inport const", 32'(rd_data[15:0]), 32'h0000_A5A5);
    // writing IN_ADDR must not disturb reads of it
    wr_en = 1; wr_addr = 3'(IN_ADDR); wr_data = 16'h0F0F;
    cyc("wr_in");
    wr_en = 0;
    cyc("rd_in_after_wr");

    // 4: same-cycle write/read
    wr_en = 1; wr_addr = 3'd2; wr_data = 16'h0011;
    cyc("wr_r2_old");
    wr_data = 16'h0055; rd_addr = {3'd2, 3'd2};
    cyc("wr_rd_r2");
    chk("bypass const", 32'(rd_data[15:0]), BYP ? 32'h55 : 32'h11);
    wr_en = 0;
    cyc("rd_r2_new");

    // 5: fill, overflow, drain, underflow
    push(32'h1000, "push1"); push(32'h2000, "push2");
    push(32'h3000, "push3"); push(32'h4000, "push4");
    chk("full const", 32'(pc_full), 32'd1);
    push(32'h5000, "push_ovf");
    chk("ovf pc_out const", pc_out, 32'h4000);
    chk("ovf err const", 32'(pc_err), 32'd1);
    pop("pop1"); pop("pop2"); pop("pop3"); pop("pop4");
    chk("drain empty const", 32'(pc_empty), 32'd1);
    pop("pop_unf");

    // 6: push+pop replace, push+pop on empty, reset mid-sequence
    rst = 1; cyc("rst_stk"); idle();
    push(32'h1000, "push_a");
    pc_push = 1; pc_pop = 1; pc_in = 32'h7777;
    cyc("pushpop");
    chk("pushpop const", pc_out, 32'h7777);
    idle();
    pop("pop_a");
    pc_push = 1; pc_pop = 1; pc_in = 32'h8888;
    cyc("pushpop_empty");
    idle();
    push(32'h9999, "push_b");
    pop("pop_b"); pop("pop_c"); pop("pop_unf2");
    pc_push = 1; pc_in = 32'hAAAA; rst = 1;
    cyc("rst_mid");
    chk("rst_mid empty const", 32'(pc_empty), 32'd1);
    idle();

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      rst     = ($urandom_range(0, 59) == 0);
      wr_en   = $urandom_range(0, 1);
      wr_addr = 3'($urandom);
      wr_data = 16'($urandom);
      inport  = 16'($urandom);
      rd_addr = 6'($urandom);
      pc_push = ($urandom_range(0, 2) == 0);
      pc_pop  = ($urandom_range(0, 2) == 0);
      pc_in   = $urandom;
      cyc("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
